// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store stage with lane steering, extension and faults.
//            Optional ACCESS wait limit enabled by macro LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_cnt;
`endif

    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Decode of the incoming request: legality, alignment and store lanes.
    always_comb begin
        w_bad   = 1'b0;
        w_be    = 4'b1111;
        w_wdata = wdata;
        if (is_store)
            w_bad = funct3[2] | (funct3[1:0] == 2'b11);
        else
            w_bad = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
        case (funct3[1:0])
            2'b01:   w_bad = w_bad | addr[0];
            2'b10:   w_bad = w_bad | (addr[1:0] != 2'b00);
            default: ;
        endcase
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {addr[1], 1'b0};
                    w_wdata = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_addr_lo)
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr_lo  <= 2'd0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            rdata      <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            r_cnt      <= 16'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_is_store <= is_store;
                        r_funct3   <= funct3;
                        r_addr_lo  <= addr[1:0];
                        req_ready  <= 1'b0;
                        stall      <= 1'b1;
                        if (w_bad) begin
                            r_state <= FAULT;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                            rdata   <= 32'd0;
                        end else begin
                            r_state   <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
                            r_cnt     <= 16'd0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    // A late ack still wins over the wait limit.
                    if (mem_ack) begin
                        r_state <= RESP;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b0;
                        rdata   <= r_is_store ? 32'd0 : w_load;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_cnt == c_timeout_last) begin
                        r_state <= FAULT;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                        rdata   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    done      <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one legal access; ack arrives after 'delay' unacked ACCESS cycles.
    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int delay,
                              input logic hold, input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input logic [31:0] e_rdata);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            check("acc_mem_req", {31'd0, mem_req}, 32'd1);
            check("acc_mem_addr", mem_addr, e_addr);
            check("acc_mem_be", {28'd0, mem_be}, {28'd0, e_be});
            check("acc_mem_we", {31'd0, mem_we}, {31'd0, st});
            if (st) check("acc_mem_wdata", mem_wdata, e_wd);
            check("acc_stall", {31'd0, stall}, 32'd1);
            check("acc_ready", {31'd0, req_ready}, 32'd0);
            check("acc_done", {31'd0, done}, 32'd0);
            if (i == delay) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end else begin
                mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        check("resp_done", {31'd0, done}, 32'd1);
        check("resp_fault", {31'd0, fault}, 32'd0);
        check("resp_rdata", rdata, e_rdata);
        check("resp_mem_req", {31'd0, mem_req}, 32'd0);
        check("resp_stall", {31'd0, stall}, 32'd1);
        check("resp_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        check("idle_stall", {31'd0, stall}, 32'd0);
    endtask

    task automatic run_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = 32'h1111_2222;
        @(negedge clk);
        req_valid = 1'b0;
        check("flt_done", {31'd0, done}, 32'd1);
        check("flt_fault", {31'd0, fault}, 32'd1);
        check("flt_rdata", rdata, 32'd0);
        check("flt_mem_req", {31'd0, mem_req}, 32'd0);
        check("flt_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        check("flt_idle_done", {31'd0, done}, 32'd0);
        check("flt_idle_ready", {31'd0, req_ready}, 32'd1);
        check("flt_idle_mem_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte loads from lane 3, signed and unsigned.
        run_access(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 1'b0,
                   32'h0000_0100, 4'b1111, 32'd0, 32'hFFFF_FF80);
        run_access(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 1'b0,
                   32'h0000_0100, 4'b1111, 32'd0, 32'h0000_0080);
        // Halfword loads.
        run_access(1'b0, 3'b001, 32'h0000_0002, 32'd0, 32'h8011_2233, 0, 1'b0,
                   32'h0000_0000, 4'b1111, 32'd0, 32'hFFFF_8011);
        run_access(1'b0, 3'b101, 32'h0000_0000, 32'd0, 32'h8011_2233, 0, 1'b0,
                   32'h0000_0000, 4'b1111, 32'd0, 32'h0000_2233);
        // Stores.
        run_access(1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 1'b0,
                   32'h0000_0020, 4'b1100, 32'hBEEF_BEEF, 32'd0);
        run_access(1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b0,
                   32'h0000_0000, 4'b0010, 32'h7878_7878, 32'd0);
        run_access(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0102_0304, 32'hFFFF_FFFF, 0, 1'b0,
                   32'hFFFF_FFFC, 4'b1111, 32'h0102_0304, 32'd0);
        // Top-word byte load.
        run_access(1'b0, 3'b000, 32'hFFFF_FFFE, 32'd0, 32'h007F_0000, 0, 1'b0,
                   32'hFFFF_FFFC, 4'b1111, 32'd0, 32'h0000_007F);
        // Delayed ack with req_valid held high throughout.
        run_access(1'b0, 3'b010, 32'h0000_0004, 32'd0, 32'hCAFE_F00D, 5, 1'b1,
                   32'h0000_0004, 4'b1111, 32'd0, 32'hCAFE_F00D);

        // Faults: misaligned and illegal encodings.
        run_fault(1'b0, 3'b010, 32'h0000_0006);
        run_fault(1'b0, 3'b011, 32'h0000_0000);
        run_fault(1'b1, 3'b001, 32'h0000_0021);
        run_fault(1'b1, 3'b100, 32'h0000_0000);

        // Stray ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_done", {31'd0, done}, 32'd0);
        check("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);

`ifdef LSU_TIMEOUT_EN
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_mem_req", {31'd0, mem_req}, 32'd1);
            @(negedge clk);
        end
        check("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check("to_done", {31'd0, done}, 32'd1);
        check("to_fault", {31'd0, fault}, 32'd1);
        @(negedge clk);
        run_access(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1357_9BDF, 3, 1'b0,
                   32'h0000_0040, 4'b1111, 32'd0, 32'h1357_9BDF);
`endif

        // Reset held for two cycles in the middle of an access.
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_mem_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h2468_ACE0;
        check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_mem_req", {31'd0, mem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address and performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a request/acknowledge data-memory port.
- It handles byte-lane steering, sign/zero extension and misalignment faults.
- It holds the core stalled until the access completes.

Parameters:
- ADDR_W, 32, width of the effective address and of mem_addr.
- TIMEOUT_CYCLES, 255, cycle limit while waiting for mem_ack. Used only with LSU_TIMEOUT_EN. Range 1..65535.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  core requests an access this cycle.
- req_ready  output  1  unit is able to accept a request.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I width/sign encoding.
- addr  input  ADDR_W  effective address (ALU result).
- wdata  input  32  store data (rs2).
- stall  output  1  hold the PC and pipeline.
- done  output  1  one-cycle pulse: access finished.
- fault  output  1  valid with done: misaligned or illegal access.
- rdata  output  32  extended load result, valid with done.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  word-aligned address (addr[1:0] forced to 00).
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  memory accepted the request / read data valid.
- mem_rdata  input  32  memory read word.

Behaviour:
- Reset (rst_n = 0 at a clock edge) forces:
  - state IDLE;
  - req_ready = 1;
  - stall, done, fault, mem_req, mem_we = 0;
  - rdata, mem_addr, mem_wdata = 0;
  - mem_be = 0000.
- Reset mid-access aborts immediately:
  - mem_req drops on that edge;
  - no done pulse is produced.
- The FSM has four states: IDLE, ACCESS, RESP, FAULT.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch is_store, funct3, addr and wdata.
  - If the access is illegal or misaligned, go to FAULT.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req = 1, stall = 1.
  - mem_addr, mem_we, mem_be and mem_wdata are registered and stay stable until mem_ack.
  - mem_ack sampled high: capture mem_rdata and go to RESP.
  - mem_ack sampled low: remain in ACCESS.
- RESP:
  - done = 1 and stall = 1 for exactly one cycle.
  - rdata is valid; rdata = 0 for stores.
  - fault = 0.
  - Return to IDLE.
- FAULT:
  - done = 1, fault = 1, rdata = 0, stall = 1 for one cycle.
  - No memory request is issued.
  - Return to IDLE.
- req_ready is 1 only in IDLE. req_valid is ignored in any other state.
- Minimum throughput is one access per 3 cycles. With ack in the first ACCESS cycle:
  - accept edge;
  - ACCESS;
  - RESP.
- stall is 1 in every non-IDLE state.
- Legal loads: funct3 = 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 = 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal and goes to FAULT.
- Misalignment rules:
  - halfword with addr[0] = 1 is misaligned;
  - word with addr[1:0] ≠ 00 is misaligned;
  - byte accesses are never misaligned.
- Store lane steering:
  - SB: mem_be = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = 0011 << (2·addr[1]); mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111; mem_wdata = wdata.
- Loads: mem_we = 0 and mem_be = 1111.
- Load lane extraction:
  - byte lane = mem_rdata[8·addr[1:0] +: 8];
  - half lane = mem_rdata[16·addr[1] +: 16].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the full word.
- mem_ack seen while not in ACCESS is ignored.
- mem_rdata is sampled only on the ACCESS cycle in which mem_ack = 1.
- An address in the top word (0xFFFFFFFC–0xFFFFFFFF) is legal; there is no wrap logic because mem_addr is aligned down.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined:
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES with mem_ack still low, mem_req drops and the FSM goes to FAULT (done = 1, fault = 1).
  - mem_ack arriving in the same cycle the limit is hit takes priority: normal RESP.
- When undefined:
  - No counter exists.
  - ACCESS waits indefinitely for mem_ack.

Test Plan:
- Reset: assert rst_n = 0 for 2 cycles mid-ACCESS -> next cycle mem_req = 0, req_ready = 1, done = 0, all outputs 0.
- LB at addr 0x00000103, mem_rdata = 0x80112233, ack on first ACCESS cycle -> mem_addr = 0x00000100, mem_be = 1111, done at cycle 3, rdata = 0xFFFFFF80. The same access as LBU -> rdata = 0x00000080.
- SH at addr 0x00000022, wdata = 0xDEADBEEF -> mem_we = 1, mem_be = 1100, mem_wdata = 0xBEEFBEEF, mem_addr = 0x00000020, done with rdata = 0.
- LW at addr 0x00000006 -> no mem_req ever, FAULT next cycle, done = 1, fault = 1. funct3 = 011 load -> same fault response.
- LW with mem_ack delayed 5 cycles, req_valid held high throughout:
  - mem_req held 6 cycles with constant mem_addr;
  - exactly one done pulse;
  - no second access is accepted until req_ready returns.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and mem_ack tied low -> mem_req drops after 4 ACCESS cycles, then done = 1, fault = 1. With ack arriving on cycle 4 -> normal RESP, fault = 0.
